esc_cmd_sequencer: RTL and testbench

// - Arbitrates throttle-update requests from NUM_CH motor-control sources.
// - Sequences each granted request as one AXI4-Lite write into the esc_controller slave register file.
// - Sits between the flight-control logic and the esc_controller S00_AXI port; it is the only master on that port.
// - Channel c writes register BASE_ADDR + 4*c.

---
 rtl/esc_ctrl_pkg.sv | 20 ++
 rtl/esc_rr_arbiter.sv | 37 +++
 rtl/esc_cmd_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_esc_cmd_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esc_ctrl_pkg.sv
// Shared definitions for the ESC command sequencer: FSM encoding, AXI
// response codes and the register stride of the esc_controller register file.
package esc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_READ   = 3'd3,
    ST_WAIT_R = 3'd4,
    ST_DONE   = 3'd5
  } esc_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  // Byte distance between consecutive channel registers.
  localparam int REG_STRIDE = 4;

endpackage

// File: rtl/esc_rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// ptr_i (wrapping at NUM_CH) and grants the first asserted request.
// The pointer itself is owned and updated by the caller.
module esc_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              valid_o,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk channels in priority order ptr, ptr+1, ... and latch the first hit.
  always_comb begin
    valid_o  = 1'b0;
    gnt_o    = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/esc_cmd_sequencer.sv
// Arbitrates throttle-update requests from NUM_CH sources and turns each
// grant into a single AXI4-Lite write to BASE_ADDR + 4*channel.
// Optional feature macro: ESC_READBACK_EN -- adds a read-back of the written
// register and flags a mismatch or read error.
//
// Handshake semantics: every AXI channel transfers on a rising edge where
// VALID and READY are both high; a master VALID, once raised, stays high with
// stable payload until that transfer, and drops right after it.
module esc_cmd_sequencer
  import esc_ctrl_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        ack,
  output logic                     err_valid,
  output logic [2:0]               err_ch,
  output logic                     busy,
  output logic [2:0]               dbg_state_o,
  output logic [ADDR_W-1:0]        M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [DATA_W-1:0]        M_AXI_WDATA,
  output logic [3:0]               M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY
`ifdef ESC_READBACK_EN
  ,
  output logic [ADDR_W-1:0]        M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [DATA_W-1:0]        M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
`endif
);

  localparam int IDX_W = $clog2(NUM_CH);

  esc_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              err_valid_q, err_valid_d;
  logic [2:0]        err_ch_q, err_ch_d;

  logic              arb_valid;
  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Requests only matter in IDLE, so the arbiter result is ignored elsewhere.
  esc_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx)
  );

  // Select register address and throttle word of the arbitration winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_idx == IDX_W'(c)) begin
        sel_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(REG_STRIDE * c);
        sel_data = req_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the grant/write/response sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    err_valid_d = 1'b0;
    err_ch_d    = err_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d   = ST_WRITE;
          gnt_d     = arb_gnt;
          idx_d     = arb_idx;
          ptr_d     = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
          awaddr_d  = sel_addr;
          wdata_d   = sel_data;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; move on once neither is pending.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_valid_d = 1'b1;
            err_ch_d    = 3'(idx_q);
          end
`ifdef ESC_READBACK_EN
          state_d = ST_READ;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef ESC_READBACK_EN
      ST_READ: begin
        if (M_AXI_ARREADY) state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (M_AXI_RVALID) begin
          if ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RDATA != wdata_q)) begin
            err_valid_d = 1'b1;
            err_ch_d    = 3'(idx_q);
          end
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight silently.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      idx_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      err_valid_q <= err_valid_d;
      err_ch_q    <= err_ch_d;
    end
  end

  assign ack           = (state_q == ST_DONE) ? gnt_q : '0;
  assign err_valid     = err_valid_q;
  assign err_ch        = err_ch_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WAIT_B);
`ifdef ESC_READBACK_EN
  assign M_AXI_ARADDR  = awaddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == ST_READ);
  assign M_AXI_RREADY  = (state_q == ST_WAIT_R);
`endif

endmodule

// File: tb/tb_esc_cmd_sequencer.sv
// Testbench for esc_cmd_sequencer: reactive AXI4-Lite slave model with
// programmable ready delays and error injection, plus scoreboards for writes,
// acks and errors. Build with ESC_READBACK_EN to include the read-back cases.
module tb_esc_cmd_sequencer;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'h4000_0100;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NUM_CH-1:0]    req;
  logic [NUM_CH*32-1:0] req_data;
  logic [NUM_CH-1:0]    ack;
  logic                 err_valid;
  logic [2:0]           err_ch;
  logic                 busy;
  logic [2:0]           dbg_state;
  logic [31:0]          awaddr;
  logic [2:0]           awprot;
  logic                 awvalid, awready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wvalid, wready;
  logic [1:0]           bresp;
  logic                 bvalid, bready;
`ifdef ESC_READBACK_EN
  logic [31:0]          araddr;
  logic [2:0]           arprot;
  logic                 arvalid, arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid, rready;
`endif

  esc_cmd_sequencer #(
    .NUM_CH    (NUM_CH),
    .BASE_ADDR (BASE),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .err_valid     (err_valid),
    .err_ch        (err_ch),
    .busy          (busy),
    .dbg_state_o   (dbg_state),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready)
`ifdef ESC_READBACK_EN
    ,
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0;
  int          aw_cnt, w_cnt;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic        aw_seen, w_seen;
  logic [31:0] wr_addr;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_seen_n, w_seen_n;
  logic [31:0] addr_n;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      wr_addr <= '0; bvalid_q <= 1'b0; bresp_q <= 2'b00;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1; else if (awvalid) aw_cnt <= 0;
      if (wvalid && !wready)   w_cnt  <= w_cnt + 1;  else if (wvalid)  w_cnt  <= 0;
      aw_seen_n = aw_seen || (awvalid && awready);
      w_seen_n  = w_seen  || (wvalid && wready);
      addr_n    = (awvalid && awready) ? awaddr : wr_addr;
      wr_addr  <= addr_n;
      if (bvalid_q && bready) bvalid_q <= 1'b0;
      if (aw_seen_n && w_seen_n && !bvalid_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (err_en && addr_n == err_addr) ? 2'b10 : 2'b00;
        aw_seen  <= 1'b0;
        w_seen   <= 1'b0;
      end else begin
        aw_seen <= aw_seen_n;
        w_seen  <= w_seen_n;
      end
    end
  end

`ifdef ESC_READBACK_EN
  logic        rd_corrupt = 1'b0;
  logic [31:0] last_wdata;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  assign arready = arvalid;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_wdata <= '0; rvalid_q <= 1'b0; rdata_q <= '0;
    end else begin
      if (wvalid && wready) last_wdata <= wdata;
      if (rvalid_q && rready) rvalid_q <= 1'b0;
      if (arvalid && arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= last_wdata ^ {31'd0, rd_corrupt};
      end
    end
  end
`endif

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [3:0]  exp_ack_q[$];
  logic [2:0]  exp_err_q[$];
  int          n_aw = 0, n_w = 0;
  logic        have_aw, have_w;
  logic [31:0] got_addr, got_data;
  logic        aw_stall, w_stall, prev_err;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [63:0] e;

  // Monitor sampled mid-cycle: VALID&READY now means a transfer at the next edge.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      have_aw = 1'b0; have_w = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; prev_err = 1'b0;
    end else begin
      if (aw_stall) check_eq("aw_hold", {31'd0, awvalid, awaddr}, {31'd0, 1'b1, prev_awaddr});
      if (w_stall)  check_eq("w_hold",  {31'd0, wvalid, wdata},   {31'd0, 1'b1, prev_wdata});
      aw_stall = awvalid && !awready; prev_awaddr = awaddr;
      w_stall  = wvalid && !wready;   prev_wdata  = wdata;
      if (awvalid && awready) begin n_aw++; got_addr = awaddr; have_aw = 1'b1; end
      if (wvalid && wready)   begin n_w++;  got_data = wdata;  have_w  = 1'b1; end
      if (have_aw && have_w) begin
        if (exp_q.size() == 0) check_eq("write_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", {32'd0, got_addr}, {32'd0, e[63:32]});
          check_eq("wr_data", {32'd0, got_data}, {32'd0, e[31:0]});
        end
        have_aw = 1'b0; have_w = 1'b0;
      end
      if (ack != '0) begin
        if (exp_ack_q.size() == 0) check_eq("ack_unexpected", {60'd0, ack}, 0);
        else check_eq("ack_ch", {60'd0, ack}, {60'd0, exp_ack_q.pop_front()});
      end
      if (err_valid) begin
        if (prev_err) check_eq("err_pulse_len", 2, 1);
        if (exp_err_q.size() == 0) check_eq("err_unexpected", 1, 0);
        else check_eq("err_ch", {61'd0, err_ch}, {61'd0, exp_err_q.pop_front()});
      end
      prev_err = err_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input int c, input logic [31:0] d);
    req_data[c*32 +: 32] = d;
    exp_q.push_back({BASE + 32'(4 * c), d});
    exp_ack_q.push_back(4'(1 << c));
  endtask

  task automatic release_acked();
    for (int c = 0; c < NUM_CH; c++) if (ack[c]) req[c] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      release_acked();
      if (exp_q.size() == 0 && exp_ack_q.size() == 0 && exp_err_q.size() == 0 &&
          !busy && req == '0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  // ---------------- stimulus ----------------
  int          cyc, lat_exp, aw0, w0;
  bit          got;
  logic [31:0] d;

  initial begin
    req = '0;
    req_data = '0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    // Reset values
    check_eq("rst_busy",    {63'd0, busy}, 0);
    check_eq("rst_awvalid", {63'd0, awvalid}, 0);
    check_eq("rst_wvalid",  {63'd0, wvalid}, 0);
    check_eq("rst_bready",  {63'd0, bready}, 0);
    check_eq("rst_ack",     {60'd0, ack}, 0);
    check_eq("rst_err",     {60'd0, err_valid, err_ch}, 0);
    check_eq("rst_awaddr",  {32'd0, awaddr}, 0);
    check_eq("rst_wdata",   {32'd0, wdata}, 0);
    check_eq("tie_prot_strb", {57'd0, awprot, wstrb}, {57'd0, 3'b000, 4'hF});
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Single request and its latency (req cycle counted as cycle 1)
`ifdef ESC_READBACK_EN
    lat_exp = 6;
`else
    lat_exp = 4;
`endif
    push_req(0, 32'h0101FFFF);
    req[0] = 1'b1;
    cyc = 1; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge ACLK); @(negedge ACLK);
      cyc++;
      if (ack[0]) got = 1;
      release_acked();
    end
    check_eq("ack_latency", cyc, lat_exp);
    wait_drain(50);

    // Contention: two full rounds, each starting at channel 0
    apply_reset();
    push_req(0, 32'habcd0001);
    push_req(1, 32'hdead0011);
    push_req(2, 32'hbeef0011);
    push_req(3, 32'h0101FFFF);
    req = 4'b1111;
    wait_drain(100);
    for (int c = 0; c < NUM_CH; c++) push_req(c, $urandom());
    req = 4'b1111;
    wait_drain(100);

    // Skewed ready in both orders: one AW and one W transfer per write
    aw0 = n_aw; w0 = n_w;
    aw_dly = 3; w_dly = 0;
    push_req(2, $urandom());
    req[2] = 1'b1;
    wait_drain(100);
    aw_dly = 0; w_dly = 3;
    push_req(0, $urandom());
    req[0] = 1'b1;
    wait_drain(100);
    w_dly = 0;
    check_eq("aw_transfers", n_aw - aw0, 2);
    check_eq("w_transfers",  n_w - w0, 2);

    // Random ready delays across all channels
    for (int k = 0; k < 6; k++) begin
      aw_dly = $urandom_range(0, 4);
      w_dly  = $urandom_range(0, 4);
      d = $urandom();
      push_req(k % NUM_CH, d);
      req[k % NUM_CH] = 1'b1;
      wait_drain(100);
    end
    aw_dly = 0; w_dly = 0;

    // Slave error on channel 2, then a clean request is still served
    err_en = 1'b1;
    err_addr = BASE + 32'd8;
    push_req(2, $urandom());
    exp_err_q.push_back(3'd2);
    req[2] = 1'b1;
    wait_drain(100);
    push_req(0, $urandom());
    req[0] = 1'b1;
    wait_drain(100);
    check_eq("err_ch_held", {61'd0, err_ch}, 2);
    err_en = 1'b0;

    // Reset while AWVALID is stalled on channel 1
    aw_dly = 20;
    push_req(1, 32'h1111_2222);
    req[1] = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK);
      if (awvalid) got = 1;
    end
    check_eq("awvalid_seen", {63'd0, got}, 1);
    ARESETN = 1'b0;
    #1;
    check_eq("midrst_valids", {62'd0, awvalid, wvalid}, 0);
    check_eq("midrst_busy_ack", {59'd0, busy, ack}, 0);
    check_eq("midrst_err_ch", {61'd0, err_ch}, 0);
    check_eq("midrst_awaddr", {32'd0, awaddr}, 0);
    repeat (2) @(negedge ACLK);
    aw_dly = 0;
    push_req(3, 32'h3333_4444);
    req[3] = 1'b1;
    ARESETN = 1'b1;
    wait_drain(100);

`ifdef ESC_READBACK_EN
    // Read-back mismatch flags an error; matching read-back does not
    rd_corrupt = 1'b1;
    push_req(1, 32'hdead0011);
    exp_err_q.push_back(3'd1);
    req[1] = 1'b1;
    wait_drain(100);
    rd_corrupt = 1'b0;
    push_req(1, 32'hdead0011);
    req[1] = 1'b1;
    wait_drain(100);
`endif

    repeat (5) @(negedge ACLK);
    check_eq("exp_q_left",     exp_q.size(), 0);
    check_eq("exp_ack_q_left", exp_ack_q.size(), 0);
    check_eq("exp_err_q_left", exp_err_q.size(), 0);
    check_eq("idle_at_end",    {63'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
